// File: rtl/switch_poller.sv
// -----------------------------------------------------------------------------
// switch_poller
//
// Periodically polls an Avalon-MM parallel-input slave for edge events and
// presents each event to a consumer through a valid/ready record port.
// One poll reads edge_capture (address 3). If any bit is set, the poller reads
// the port levels (address 0), clears edge_capture with one all-ones write and
// holds the record until the consumer takes it.
//
// Parameters
//   WIDTH     width of the polled port and of the event vectors
//   POLL_DIV  clk cycles between poll starts (8..65535)
//
// Ports
//   clk            single clock, rising edge
//   reset          synchronous, active-high
//   m_address      slave register select (0 data, 2 irq_mask, 3 edge_capture)
//   m_chipselect   slave select
//   m_write_n      active-low write strobe
//   m_writedata    write data to slave
//   m_readdata     slave read data, valid the cycle after the read cycle
//   event_valid    event record available
//   event_ready    consumer accepts the record
//   event_changed  captured edge bits
//   event_level    port levels read after the capture
//   busy           high whenever the poller is not in IDLE
//   irq            (SWITCH_POLLER_IRQ_EN only) level interrupt from the slave
//
// Configuration
//   SWITCH_POLLER_IRQ_EN  when defined, adds the irq input. The interrupt mask
//                         is written to all-ones once after reset, and an
//                         asserted irq starts a poll without waiting for the
//                         timer.
// -----------------------------------------------------------------------------
module switch_poller #(
  parameter int WIDTH    = 10,
  parameter int POLL_DIV = 1000
) (
  input  logic             clk,
  input  logic             reset,
`ifdef SWITCH_POLLER_IRQ_EN
  input  logic             irq,
`endif
  output logic [1:0]       m_address,
  output logic             m_chipselect,
  output logic             m_write_n,
  output logic [WIDTH-1:0] m_writedata,
  input  logic [WIDTH-1:0] m_readdata,
  output logic             event_valid,
  input  logic             event_ready,
  output logic [WIDTH-1:0] event_changed,
  output logic [WIDTH-1:0] event_level,
  output logic             busy
);

  localparam logic [15:0] RELOAD = 16'(POLL_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_CAP,
    WT_CAP,
    RD_LVL,
    WT_LVL,
    WR_CLR,
    PRESENT
`ifdef SWITCH_POLLER_IRQ_EN
    , WR_MASK
`endif
  } state_t;

  state_t      state;
  logic [15:0] poll_cnt;
  logic        poll_start;

`ifdef SWITCH_POLLER_IRQ_EN
  logic mask_pending;

  // An asserted interrupt starts a poll early; the timer remains a fallback.
  always_comb begin
    poll_start = (poll_cnt == 16'd0) || irq;
  end
`else
  always_comb begin
    poll_start = (poll_cnt == 16'd0);
  end
`endif

  // All bus outputs are registered. They are loaded on the edge that enters a
  // bus state, so they are valid for exactly the cycle spent in that state.
  // By default every edge returns the bus to idle, so each bus cycle lasts
  // exactly one clock. The poll counter runs only in IDLE and is reloaded
  // whenever IDLE is entered or left.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      poll_cnt      <= RELOAD;
      m_address     <= 2'd0;
      m_chipselect  <= 1'b0;
      m_write_n     <= 1'b1;
      m_writedata   <= '0;
      event_valid   <= 1'b0;
      event_changed <= '0;
      event_level   <= '0;
      busy          <= 1'b0;
`ifdef SWITCH_POLLER_IRQ_EN
      mask_pending  <= 1'b1;
`endif
    end else begin
      m_address    <= 2'd0;
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_writedata  <= '0;

      case (state)
        IDLE: begin
`ifdef SWITCH_POLLER_IRQ_EN
          if (mask_pending) begin
            // One-time unmask of every slave interrupt before polling begins.
            state        <= WR_MASK;
            busy         <= 1'b1;
            mask_pending <= 1'b0;
            m_address    <= 2'd2;
            m_chipselect <= 1'b1;
            m_write_n    <= 1'b0;
            m_writedata  <= '1;
          end else
`endif
          if (poll_start) begin
            state        <= RD_CAP;
            busy         <= 1'b1;
            poll_cnt     <= RELOAD;
            m_address    <= 2'd3;
            m_chipselect <= 1'b1;
          end else begin
            poll_cnt <= poll_cnt - 16'd1;
          end
        end

        RD_CAP: state <= WT_CAP;

        WT_CAP: begin
          event_changed <= m_readdata;
          if (m_readdata != '0) begin
            state        <= RD_LVL;
            m_address    <= 2'd0;
            m_chipselect <= 1'b1;
          end else begin
            state    <= IDLE;
            busy     <= 1'b0;
            poll_cnt <= RELOAD;
          end
        end

        RD_LVL: state <= WT_LVL;

        WT_LVL: begin
          // The slave clear is whole-register. Edges that land between the
          // capture read and this write are lost by design.
          event_level  <= m_readdata;
          state        <= WR_CLR;
          m_address    <= 2'd3;
          m_chipselect <= 1'b1;
          m_write_n    <= 1'b0;
          m_writedata  <= '1;
        end

        WR_CLR: begin
          state       <= PRESENT;
          event_valid <= 1'b1;
        end

        PRESENT: begin
          if (event_ready) begin
            state       <= IDLE;
            event_valid <= 1'b0;
            busy        <= 1'b0;
            poll_cnt    <= RELOAD;
          end
        end

`ifdef SWITCH_POLLER_IRQ_EN
        WR_MASK: begin
          state    <= IDLE;
          busy     <= 1'b0;
          poll_cnt <= RELOAD;
        end
`endif

        default: begin
          state       <= IDLE;
          busy        <= 1'b0;
          event_valid <= 1'b0;
          poll_cnt    <= RELOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_switch_poller.sv
// -----------------------------------------------------------------------------
// tb_switch_poller
//
// Self-checking bench for switch_poller (WIDTH=10, POLL_DIV=8). A behavioural
// parallel-input slave with edge capture answers the poller's bus cycles.
// Expected event records are queued when an edge is applied and compared when
// the poller hands a record over. Bus cycles are logged with cycle stamps so
// that poll timing and the clear write can be checked.
// -----------------------------------------------------------------------------
module tb_switch_poller;

  localparam int WIDTH    = 10;
  localparam int POLL_DIV = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       m_address;
  logic             m_chipselect;
  logic             m_write_n;
  logic [WIDTH-1:0] m_writedata;
  logic [WIDTH-1:0] m_readdata;
  logic             event_valid;
  logic             event_ready = 1'b0;
  logic [WIDTH-1:0] event_changed;
  logic [WIDTH-1:0] event_level;
  logic             busy;
`ifdef SWITCH_POLLER_IRQ_EN
  logic             irq = 1'b0;
`endif

  switch_poller #(.WIDTH(WIDTH), .POLL_DIV(POLL_DIV)) dut (
    .clk          (clk),
    .reset        (reset),
`ifdef SWITCH_POLLER_IRQ_EN
    .irq          (irq),
`endif
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata),
    .m_readdata   (m_readdata),
    .event_valid  (event_valid),
    .event_ready  (event_ready),
    .event_changed(event_changed),
    .event_level  (event_level),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               cyc;
    logic [1:0]       addr;
    logic             wr;
    logic [WIDTH-1:0] data;
  } bus_t;

  typedef struct {
    logic [WIDTH-1:0] changed;
    logic [WIDTH-1:0] level;
  } rec_t;

  bus_t bus_log[$];
  rec_t sb[$];

  int   cycle = 0;
  int   rst_cycle = 0;
  int   valid_cycles = 0;
  int   valid_rise_cycle = -1;
  logic prev_valid = 1'b0;
  int   check_count = 0;
  int   error_count = 0;

  // Slave model: input port, edge capture cleared by any write to address 3,
  // registered read data (one cycle read latency).
  logic [WIDTH-1:0] in_port = '0;
  logic [WIDTH-1:0] prev_port = '0;
  logic [WIDTH-1:0] edge_cap = '0;
  logic [WIDTH-1:0] rd_data = '0;

  assign m_readdata = rd_data;

  always @(posedge clk) begin
    prev_port <= in_port;
    if (m_chipselect === 1'b1 && m_write_n === 1'b0 && m_address === 2'd3)
      edge_cap <= '0;
    else
      edge_cap <= edge_cap | (in_port ^ prev_port);
    case (m_address)
      2'd0:    rd_data <= in_port;
      2'd3:    rd_data <= edge_cap;
      default: rd_data <= '0;
    endcase
  end

  // Cycle stamp and the stamp of the most recent edge taken in reset.
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (reset) rst_cycle <= cycle + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    assert (observed === expected) else begin
      error_count++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Bus log, valid tracking and scoreboard comparison on each handover.
  always @(negedge clk) begin
    if (m_chipselect === 1'b1)
      bus_log.push_back('{cycle, m_address, ~m_write_n, m_writedata});
    if (event_valid === 1'b1) valid_cycles++;
    if (event_valid === 1'b1 && prev_valid !== 1'b1) valid_rise_cycle = cycle;
    prev_valid = event_valid;
    if (event_valid === 1'b1 && event_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected event", 32'd1, 32'd0);
      end else begin
        rec_t exp_rec;
        exp_rec = sb.pop_front();
        checkOutput("event_changed", 32'(event_changed), 32'(exp_rec.changed));
        checkOutput("event_level", 32'(event_level), 32'(exp_rec.level));
      end
    end
  end

  // Flip port bits just after a rising edge; queue the record if one is due.
  task automatic applyStimulus(input logic [WIDTH-1:0] flip, input bit expect_event);
    @(posedge clk);
    #1;
    in_port = in_port ^ flip;
    if (expect_event) sb.push_back('{flip, in_port});
  endtask

  task automatic waitValid(input string tag, input int limit);
    logic seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (event_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput({tag, " valid seen"}, 32'(seen), 32'd1);
  endtask

  // Raise ready; the record must be gone on the very next cycle.
  task automatic acceptEvent(input string tag);
    int waited = 0;
    @(posedge clk);
    #1;
    event_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (event_valid !== 1'b1) break;
      waited++;
    end
    checkOutput({tag, " accept latency"}, 32'(waited), 32'd1);
    checkOutput({tag, " busy after accept"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    event_ready = 1'b0;
  endtask

  function automatic int countWrites(input int from);
    int n = 0;
    for (int i = from; i < bus_log.size(); i++)
      if (bus_log[i].wr) n++;
    return n;
  endfunction

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " event_valid"}, 32'(event_valid), 32'd0);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " m_chipselect"}, 32'(m_chipselect), 32'd0);
    checkOutput({tag, " m_write_n"}, 32'(m_write_n), 32'd1);
    checkOutput({tag, " m_address"}, 32'(m_address), 32'd0);
    checkOutput({tag, " m_writedata"}, 32'(m_writedata), 32'd0);
    checkOutput({tag, " event_changed"}, 32'(event_changed), 32'd0);
    checkOutput({tag, " event_level"}, 32'(event_level), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not reach its end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   mark;
    int   hold_start;
    int   bad;
    int   busy_bad;
    int   n;
    logic found;

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetValues("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus_log.delete();
    valid_cycles = 0;

    // Quiet port: one capture read every POLL_DIV+2 cycles, nothing else
    repeat (41) @(negedge clk);
    checkOutput("idle poll count", 32'(bus_log.size()), 32'd4);
    bad = 0;
    foreach (bus_log[i]) if (bus_log[i].wr || bus_log[i].addr != 2'd3) bad++;
    checkOutput("idle reads addr3 only", 32'(bad), 32'd0);
    if (bus_log.size() >= 2) begin
      checkOutput("first poll delay", 32'(bus_log[0].cyc - rst_cycle), 32'(POLL_DIV));
      checkOutput("idle poll period", 32'(bus_log[1].cyc - bus_log[0].cyc), 32'(POLL_DIV + 2));
    end
    checkOutput("idle no event", 32'(valid_cycles), 32'd0);

    // Bit 3 toggle, then hold the record for 20 cycles
    mark = bus_log.size();
    applyStimulus(10'h008, 1'b1);
    waitValid("bit3", 40);
    hold_start = bus_log.size();
    bad = 0;
    busy_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (event_valid !== 1'b1 || event_changed !== 10'h008 || event_level !== 10'h008) bad++;
      if (busy !== 1'b1) busy_bad++;
    end
    checkOutput("hold record stable", 32'(bad), 32'd0);
    checkOutput("hold busy", 32'(busy_bad), 32'd0);
    checkOutput("hold no bus cycles", 32'(bus_log.size() - hold_start), 32'd0);
    checkOutput("bit3 write count", 32'(countWrites(mark)), 32'd1);
    n = hold_start;
    if (n - mark >= 3) begin
      checkOutput("clear is write", 32'(bus_log[n-1].wr), 32'd1);
      checkOutput("clear address", 32'(bus_log[n-1].addr), 32'd3);
      checkOutput("clear data", 32'(bus_log[n-1].data), 32'h3FF);
      checkOutput("level read address", 32'(bus_log[n-2].addr), 32'd0);
      checkOutput("event latency", 32'(valid_rise_cycle - bus_log[n-3].cyc), 32'd5);
    end else begin
      checkOutput("bit3 bus cycles", 32'(n - mark), 32'd3);
    end
    acceptEvent("bit3");

    // Several bits changing at once, both directions
    applyStimulus(10'h209, 1'b1);
    waitValid("multi", 40);
    acceptEvent("multi");

    // Edge arriving between capture read and clear write is dropped
    applyStimulus(10'h004, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_chipselect === 1'b1 && m_write_n === 1'b1 && m_address === 2'd0) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("level read seen", 32'(found), 32'd1);
    applyStimulus(10'h002, 1'b0);
    waitValid("drop", 20);
    acceptEvent("drop");
    valid_cycles = 0;
    mark = bus_log.size();
    repeat (30) @(negedge clk);
    checkOutput("dropped edge no event", 32'(valid_cycles), 32'd0);
    checkOutput("dropped edge no write", 32'(countWrites(mark)), 32'd0);

    // Reset taken in WR_CLR aborts the event
    applyStimulus(10'h020, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_chipselect === 1'b1 && m_write_n === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("wr_clr seen", 32'(found), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    checkResetValues("abort");
    sb.delete();
    bus_log.delete();
    valid_cycles = 0;
    reset = 1'b0;
    repeat (25) @(negedge clk);
    checkOutput("abort no write", 32'(countWrites(0)), 32'd0);
    checkOutput("abort no event", 32'(valid_cycles), 32'd0);
    if (bus_log.size() > 0)
      checkOutput("abort first poll delay", 32'(bus_log[0].cyc - rst_cycle), 32'(POLL_DIV));
    else
      checkOutput("abort poll seen", 32'd0, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
